// File: rtl/atm_pin_checker.sv
// atm_pin_checker: keypad PIN collection and verification ahead of the ATM
// session FSM. Digits are buffered per card insertion, checked against a
// per-account PIN register file, and a one-cycle verdict pulse is issued
// with a held wrong_psw level.
// Optional feature macro: ATM_PIN_LOCKOUT_EN (per-account fail counter and
// lock bit; three consecutive mismatches lock the account until reprogrammed).
module atm_pin_checker #(
  parameter int unsigned PIN_DIGITS = 4,
  parameter int unsigned ACCOUNTS   = 4,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               card_in,
  input  logic [ID_WIDTH-1:0]                card_id,
  input  logic                               key_valid,
  input  logic [3:0]                         key_code,
  input  logic                               prog_we,
  input  logic [ID_WIDTH-1:0]                prog_id,
  input  logic [4*PIN_DIGITS-1:0]            prog_pin,
  output logic                               pin_valid,
  output logic                               wrong_psw,
  output logic [$clog2(PIN_DIGITS+1)-1:0]    digit_count,
  output logic                               busy,
  output logic                               card_locked
);

  localparam int unsigned BUF_W = 4 * PIN_DIGITS;
  localparam int unsigned CNT_W = $clog2(PIN_DIGITS + 1);
  localparam int unsigned IDX_W = ID_WIDTH + 1;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_ENTER     = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMPARE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BUF_W-1:0]    pin_buf_q, buf_d;
  logic [CNT_W-1:0]    cnt_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                valid_d;
  logic                wrong_d;
  logic [BUF_W-1:0]    pin_mem [ACCOUNTS];

  logic id_ok;
  logic id_d_ok;
  logic prog_ok;
  logic match;
  logic locked_now;
  logic verdict_bad;

  // Address range qualifiers for the sampled account, next account and programming port
  assign id_ok   = ({1'b0, id_q}    < IDX_W'(ACCOUNTS));
  assign id_d_ok = ({1'b0, id_d}    < IDX_W'(ACCOUNTS));
  assign prog_ok = ({1'b0, prog_id} < IDX_W'(ACCOUNTS));

  // A full entry equal to the stored PIN of the sampled account
  assign match = id_ok && (digit_count == CNT_W'(PIN_DIGITS)) &&
                 (pin_buf_q == pin_mem[id_q]);

  assign verdict_bad = !match || locked_now;

  // Next-state, buffer and verdict logic; card removal overrides everything
  always_comb begin
    state_d = state_q;
    buf_d   = pin_buf_q;
    cnt_d   = digit_count;
    id_d    = id_q;
    valid_d = 1'b0;
    wrong_d = wrong_psw;
    if (!card_in) begin
      state_d = S_IDLE;
      buf_d   = '0;
      cnt_d   = '0;
      wrong_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_COLLECT;
          id_d    = card_id;
          buf_d   = '0;
          cnt_d   = '0;
        end
        S_COLLECT: begin
          if (key_valid) begin
            if (key_code <= KEY_DIGIT_MAX) begin
              if (digit_count < CNT_W'(PIN_DIGITS)) begin
                buf_d = {pin_buf_q[BUF_W-5:0], key_code};
                cnt_d = digit_count + CNT_W'(1);
              end
            end else if (key_code == KEY_CLEAR) begin
              buf_d = '0;
              cnt_d = '0;
            end else if (key_code == KEY_ENTER) begin
              state_d = S_COMPARE;
            end
          end
        end
        S_COMPARE: begin
          valid_d = 1'b1;
          wrong_d = verdict_bad;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = S_COLLECT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, entry buffer and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pin_buf_q   <= '0;
      digit_count <= '0;
      id_q        <= '0;
      pin_valid   <= 1'b0;
      wrong_psw   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pin_buf_q   <= buf_d;
      digit_count <= cnt_d;
      id_q        <= id_d;
      pin_valid   <= valid_d;
      wrong_psw   <= wrong_d;
      busy        <= (state_d != S_IDLE);
    end
  end

  // PIN register file; a write in the compare cycle lands after the compare reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ACCOUNTS; i++) pin_mem[i] <= '0;
    end else if (prog_we && prog_ok) begin
      pin_mem[prog_id] <= prog_pin;
    end
  end

`ifdef ATM_PIN_LOCKOUT_EN
  logic [1:0]          fail_q [ACCOUNTS];
  logic [1:0]          fail_d [ACCOUNTS];
  logic [ACCOUNTS-1:0] lock_q, lock_d;
  logic                cmp_fire;

  assign cmp_fire   = card_in && (state_q == S_COMPARE);
  assign locked_now = id_ok && lock_q[id_q];

  // Fail counter / lock update on each verdict; programming an account clears both
  always_comb begin
    fail_d = fail_q;
    lock_d = lock_q;
    if (cmp_fire && id_ok) begin
      if (verdict_bad) begin
        if (fail_q[id_q] >= 2'd2) lock_d[id_q] = 1'b1;
        if (fail_q[id_q] != 2'd3) fail_d[id_q] = fail_q[id_q] + 2'd1;
      end else begin
        fail_d[id_q] = 2'd0;
      end
    end
    if (prog_we && prog_ok) begin
      fail_d[prog_id] = 2'd0;
      lock_d[prog_id] = 1'b0;
    end
  end

  // Lockout state and the registered lock indication for the active card
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ACCOUNTS; i++) fail_q[i] <= 2'd0;
      lock_q      <= '0;
      card_locked <= 1'b0;
    end else begin
      fail_q      <= fail_d;
      lock_q      <= lock_d;
      card_locked <= (state_d != S_IDLE) && id_d_ok && lock_d[id_d];
    end
  end
`else
  assign locked_now  = 1'b0;
  assign card_locked = 1'b0;
`endif

endmodule

// File: tb/tb_atm_pin_checker.sv
// Scoreboard bench for atm_pin_checker: drivers update a behavioural account
// model and queue expected verdicts; a negedge monitor matches verdict pulses.
module tb_atm_pin_checker;

  localparam int PD = 4;
  localparam int NA = 4;
  localparam int IW = 2;

  logic          clk, rst, card_in, key_valid, prog_we;
  logic [IW-1:0] card_id, prog_id;
  logic [3:0]    key_code;
  logic [15:0]   prog_pin;
  logic          pin_valid, wrong_psw, busy, card_locked;
  logic [2:0]    digit_count;

  atm_pin_checker #(.PIN_DIGITS(PD), .ACCOUNTS(NA), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .card_id(card_id),
    .key_valid(key_valid), .key_code(key_code),
    .prog_we(prog_we), .prog_id(prog_id), .prog_pin(prog_pin),
    .pin_valid(pin_valid), .wrong_psw(wrong_psw), .digit_count(digit_count),
    .busy(busy), .card_locked(card_locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { int cyc; bit wrong; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Behavioural model of accounts and the entry in progress
  int m_pin[NA];
  bit m_lock[NA];
`ifdef ATM_PIN_LOCKOUT_EN
  int m_fail[NA];
`endif
  int m_digits[$];
  bit m_card = 1'b0;
  int m_id   = 0;
  bit m_cmp  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Verdict monitor: every pulse must match the oldest expectation and its cycle
  always @(negedge clk) begin
    if (rst) begin
      if (pin_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("verdict_cycle", cyc, mon_e.cyc);
          check("verdict_wrong_psw", int'(wrong_psw), int'(mon_e.wrong));
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        check("missing_pulse", 0, 1);
      end
    end
  end

  function automatic int entry_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  function automatic int locked_now();
    return (m_card && m_lock[m_id]) ? 1 : 0;
  endfunction

  function automatic void do_verdict();
    exp_t e;
    bit   match;
    match = (m_digits.size() == PD) && (entry_value() == m_pin[m_id]);
    e.wrong = !match;
`ifdef ATM_PIN_LOCKOUT_EN
    if (m_lock[m_id]) e.wrong = 1'b1;
    if (e.wrong) begin
      m_fail[m_id]++;
      if (m_fail[m_id] >= 3) m_lock[m_id] = 1'b1;
    end else begin
      m_fail[m_id] = 0;
    end
`endif
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    m_digits.delete();
  endfunction

  task automatic press(input int k);
    bit was_cmp;
    key_valid = 1'b1;
    key_code  = 4'(k);
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    was_cmp = m_cmp;
    m_cmp   = 1'b0;
    if (m_card && !was_cmp) begin
      if (k <= 9) begin
        if (m_digits.size() < PD) m_digits.push_back(k);
      end else if (k == 10) begin
        m_digits.delete();
      end else if (k == 11) begin
        do_verdict();
        m_cmp = 1'b1;
      end
    end
    if (!m_cmp) begin
      check("digit_count", int'(digit_count), m_digits.size());
      check("busy", int'(busy), int'(m_card));
      check("card_locked", int'(card_locked), locked_now());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
    m_cmp = 1'b0;
  endtask

  task automatic insert(input int id);
    card_id = IW'(id);
    card_in = 1'b1;
    @(posedge clk); #1;
    m_card = 1'b1;
    m_id   = id;
    m_cmp  = 1'b0;
    m_digits.delete();
    check("busy_after_insert", int'(busy), 1);
    check("count_after_insert", int'(digit_count), 0);
    check("locked_after_insert", int'(card_locked), locked_now());
  endtask

  task automatic remove_card();
    if (m_cmp) idle(1);
    card_in = 1'b0;
    @(posedge clk); #1;
    m_card = 1'b0;
    m_digits.delete();
    check("busy_after_remove", int'(busy), 0);
    check("count_after_remove", int'(digit_count), 0);
    check("wrong_after_remove", int'(wrong_psw), 0);
    check("locked_after_remove", int'(card_locked), 0);
  endtask

  task automatic enter_abort();
    key_valid = 1'b1;
    key_code  = 4'hB;
    card_in   = 1'b0;
    @(posedge clk); #1;
    key_valid = 1'b0;
    m_card = 1'b0;
    m_cmp  = 1'b0;
    m_digits.delete();
    check("busy_after_abort", int'(busy), 0);
  endtask

  task automatic prog(input int id, input int pin);
    prog_we  = 1'b1;
    prog_id  = IW'(id);
    prog_pin = 16'(pin);
    @(posedge clk); #1;
    prog_we = 1'b0;
    m_pin[id]  = pin;
    m_lock[id] = 1'b0;
`ifdef ATM_PIN_LOCKOUT_EN
    m_fail[id] = 0;
`endif
    m_cmp = 1'b0;
  endtask

  task automatic key_seq(input int keys[$]);
    foreach (keys[i]) press(keys[i]);
  endtask

  function automatic int pin_digit(input int id, input int i);
    return (m_pin[id] >> (4 * (PD - 1 - i))) & 15;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NA; i++) begin
      m_pin[i]  = 0;
      m_lock[i] = 1'b0;
`ifdef ATM_PIN_LOCKOUT_EN
      m_fail[i] = 0;
`endif
    end
    m_digits.delete();
    m_card = 1'b0;
    m_cmp  = 1'b0;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int keys[$];
    int id, kind, pin, n;
    rst = 1'b0; card_in = 1'b0; card_id = '0; key_valid = 1'b0; key_code = '0;
    prog_we = 1'b0; prog_id = '0; prog_pin = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_pin_valid", int'(pin_valid), 0);
    check("rst_wrong_psw", int'(wrong_psw), 0);
    check("rst_digit_count", int'(digit_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_card_locked", int'(card_locked), 0);

    // Keys with no card are dropped
    press(1); press(11);

    prog(1, 'h1234);
    insert(1);
    key_seq('{1, 2, 3, 4, 11}); idle(2);
    key_seq('{1, 2, 3, 5, 11}); idle(1);
    key_seq('{1, 2, 3, 4, 11}); idle(2);
    key_seq('{1, 2, 11}); idle(1);
    key_seq('{1, 2, 3, 4, 5, 6});
    check("saturated_count", int'(digit_count), 4);
    press(11); idle(1);
    key_seq('{9, 9, 10, 1, 2, 3, 4, 11});
    press(7);                       // lands in the compare cycle and is dropped
    key_seq('{1, 2});
    remove_card();

    insert(2);
    key_seq('{0, 0, 0, 0, 11}); idle(1);
    key_seq('{0, 0, 0});
    enter_abort();
    idle(3);

    // Programming the active account during its compare cycle
    insert(1);
    key_seq('{1, 2, 3, 4, 11});
    prog(1, 'h5678);
    key_seq('{1, 2, 3, 4, 11}); idle(1);
    key_seq('{5, 6, 7, 8, 11}); idle(2);
    check("wrong_after_new_pin", int'(wrong_psw), 0);
    remove_card();

`ifdef ATM_PIN_LOCKOUT_EN
    prog(1, 'h1234);
    insert(1);
    repeat (3) begin
      key_seq('{1, 2, 3, 5, 11}); idle(1);
    end
    idle(1);
    check("locked_after_three", int'(card_locked), 1);
    key_seq('{1, 2, 3, 4, 11}); idle(2);
    check("locked_verdict", int'(wrong_psw), 1);
    prog(1, 'h1234);
    check("unlocked_after_prog", int'(card_locked), 0);
    key_seq('{1, 2, 3, 4, 11}); idle(2);
    check("unlocked_verdict", int'(wrong_psw), 0);
    remove_card();
`endif

    // Reset mid-entry wipes the register file
    prog(3, 'h9876);
    insert(3);
    key_seq('{9, 8});
    #2;
    rst = 1'b0;
    card_in = 1'b0;
    #1;
    check("midrst_count", int'(digit_count), 0);
    check("midrst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    insert(3);
    key_seq('{0, 0, 0, 0, 11}); idle(2);
    check("midrst_default_pin", int'(wrong_psw), 0);
    remove_card();

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      id = $urandom_range(0, NA - 1);
      if ($urandom_range(0, 2) == 0) begin
        pin = 0;
        for (int i = 0; i < PD; i++) pin = pin * 16 + $urandom_range(0, 9);
        prog(id, pin);
      end
      if ($urandom_range(0, 3) == 0) press($urandom_range(0, 11));
      insert(id);
      n = $urandom_range(1, 4);
      for (int a = 0; a < n; a++) begin
        keys.delete();
        kind = $urandom_range(0, 5);
        case (kind)
          0: for (int i = 0; i < PD; i++) keys.push_back(pin_digit(id, i));
          1: begin
            int bi;
            bi = $urandom_range(0, PD - 1);
            for (int i = 0; i < PD; i++)
              keys.push_back(i == bi ? (pin_digit(id, i) + 1 + $urandom_range(0, 8)) % 10
                                     : pin_digit(id, i));
          end
          2: begin
            int c;
            c = $urandom_range(0, PD - 1);
            for (int i = 0; i < c; i++) keys.push_back(pin_digit(id, i));
          end
          3: begin
            for (int i = 0; i < PD; i++) keys.push_back(pin_digit(id, i));
            repeat ($urandom_range(1, 2)) keys.push_back($urandom_range(0, 9));
          end
          4: begin
            repeat ($urandom_range(1, 3)) keys.push_back($urandom_range(0, 9));
            keys.push_back(10);
            for (int i = 0; i < PD; i++) keys.push_back(pin_digit(id, i));
          end
          default: begin
            for (int i = 0; i < PD; i++) begin
              keys.push_back(pin_digit(id, i));
              if ($urandom_range(0, 1) == 0) keys.push_back($urandom_range(12, 15));
            end
          end
        endcase
        keys.push_back(11);
        foreach (keys[i]) begin
          press(keys[i]);
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        if ($urandom_range(0, 2) != 0) idle(1);
      end
      idle(1);
      remove_card();
      idle($urandom_range(0, 2));
    end

    idle(4);
    check("pending_verdicts", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atm_pin_checker.md
# atm_pin_checker

Keypad PIN entry and verification stage that sits directly upstream of the ATM session FSM. It collects BCD digits from the keypad while a card is inserted and compares the entry against a per-account PIN register file. It then issues a one-cycle verdict pulse with a held `wrong_psw` level, which the session FSM samples in its password state. Per-account PINs are written through a simple programming port.

## Interface
Parameters:
- `PIN_DIGITS`, 4: digits per PIN; each digit is one 4-bit BCD nibble.
- `ACCOUNTS`, 4: number of PIN entries in the register file.
- `ID_WIDTH`, 2: account index width; `ACCOUNTS` ≤ 2^`ID_WIDTH`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `card_in`  in  1  card present; low aborts any entry.
- `card_id`  in  `ID_WIDTH`  account index; sampled on IDLE→COLLECT.
- `key_valid`  in  1  one-cycle strobe per keypress.
- `key_code`  in  4  keypress code:
  - 0–9: digit.
  - 4'hA: clear.
  - 4'hB: enter.
  - 4'hC–4'hF: ignored.
- `prog_we`  in  1  write `prog_pin` to `pin_mem[prog_id]`.
- `prog_id`  in  `ID_WIDTH`  programming index.
- `prog_pin`  in  4*`PIN_DIGITS`  PIN value; first digit in the MS nibble.
- `pin_valid`  out  1  one-cycle verdict pulse.
- `wrong_psw`  out  1  verdict level: 1 = mismatch.
- `digit_count`  out  $clog2(`PIN_DIGITS`+1)  digits currently buffered.
- `busy`  out  1  high in COLLECT and COMPARE.
- `card_locked`  out  1  sampled account is locked (see Configuration).

## Operation
States and transitions:
- **IDLE**:
  - If `card_in`=1: go to COLLECT, latch `card_id` into `id_q`, clear the buffer and `digit_count`.
- **COLLECT**:
  - Digit key while `digit_count` < `PIN_DIGITS`: `buf <= {buf[4*PIN_DIGITS-5:0], key_code}` and increment `digit_count`.
  - Digit key while `digit_count` = `PIN_DIGITS`: ignored.
  - Clear key: `buf` = 0, `digit_count` = 0.
  - Enter key: go to COMPARE.
- **COMPARE** (exactly one cycle):
  - `match = (digit_count == PIN_DIGITS) && (buf == pin_mem[id_q])`.
  - Register `wrong_psw <= !match` and `pin_valid <= 1`.
  - Clear the buffer and `digit_count`, then return to COLLECT so the user can retry.
- Any state with `card_in`=0: go to IDLE next cycle; `buf`, `digit_count` and `wrong_psw` cleared; no verdict issued.

Data and boundary rules:
- `wrong_psw` holds its value until the next verdict or until card removal.
- Keys arriving while in COMPARE or IDLE are dropped.
- `pin_mem` reset value is all zeros, so every account's default PIN is 0000.
- `prog_we` is accepted in any state. `prog_id` ≥ `ACCOUNTS` is ignored.
- `prog_we` to `id_q` in the same cycle as COMPARE: the compare uses the old PIN; the new value is visible from the next cycle.
- `card_in` falling in the same cycle as an enter key: the abort wins and no `pin_valid` is produced.
- Reset mid-entry: immediate return to IDLE; `pin_mem` returns to zeros.

## Timing
- Reset values: `pin_valid`=0, `wrong_psw`=0, `digit_count`=0, `busy`=0, `card_locked`=0; state = IDLE.
- `card_in` rising in cycle N: `busy`=1 in cycle N+1.
- Digit key sampled at edge N: `digit_count` updates after that edge.
- Enter sampled at edge N: COMPARE during cycle N+1; `pin_valid` and `wrong_psw` valid in cycle N+2; `pin_valid` is high for exactly one cycle.
- Maximum key rate: one key per cycle; no backpressure.

## Configuration
`ATM_PIN_LOCKOUT_EN`:
- **Defined:**
  - Per-account 2-bit fail counter and lock bit.
  - Each mismatch verdict increments the counter; a match clears it.
  - The third consecutive mismatch sets the lock bit.
  - While `id_q`'s lock bit is set, every verdict is `wrong_psw`=1 regardless of the entry.
  - `card_locked` = lock bit of `id_q` while `busy`, else 0.
  - `prog_we` to an account clears its counter and lock bit.
  - Counters and lock bits reset to 0.
- **Undefined:** no counters or lock bits; `card_locked` is tied to 0.

## Test plan
- Program id 1 with PIN 1234. Insert card with `card_id`=1, key 1,2,3,4, enter → `pin_valid` pulse 2 cycles after enter, `wrong_psw`=0.
- Same account, key 1,2,3,5, enter → `pin_valid` pulse, `wrong_psw`=1. Then key 1,2,3,4, enter → `wrong_psw`=0.
- Key 1,2, enter → `wrong_psw`=1. Key 1,2,3,4,5,6 → `digit_count` saturates at 4; enter → match.
- Key 9,9, clear, 1,2,3,4, enter → match. Drop `card_in` after two digits → `digit_count`=0, `busy`=0, no pulse.
- Never-programmed account 2: 0,0,0,0, enter → match. Enter and `card_in` fall in the same cycle → no pulse.
- With `ATM_PIN_LOCKOUT_EN`:
  - 3 wrong entries → `card_locked`=1; correct 1234 then gives `wrong_psw`=1.
  - Reprogram id 1 → lock cleared, 1234 matches.
